// File: rtl/sram_arbiter_if.sv
// Shared-SRAM port bundle: AVR external-slave bus, DMA request bus and the memory port.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              avr_cs;
  logic              avr_oe;
  logic              avr_we;
  logic [ADDR_W-1:0] avr_a;
  logic [7:0]        avr_dout;
  logic [7:0]        avr_din;
  logic              avr_wait;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_a;
  logic [7:0]        dma_wdata;
  logic              dma_ack;
  logic [7:0]        dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  avr_cs, avr_oe, avr_we, avr_a, avr_dout,
    output avr_din, avr_wait,
    input  dma_req, dma_we, dma_a, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_en, mem_we, mem_a, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output avr_cs, avr_oe, avr_we, avr_a, avr_dout,
    input  avr_din, avr_wait,
    output dma_req, dma_we, dma_a, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_a, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one synchronous SRAM between an AVR slave bus and a DMA port.
// Write done 2 cycles after grant, read 2+RD_WS; AVR stalled via avr_wait, DMA holds dma_req until dma_ack.
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int RD_WS  = 1
) (
  input  logic          clk,
  input  logic          nrst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       OWN_AVR = 1'b0;
  localparam logic       OWN_DMA = 1'b1;
  localparam logic [2:0] RD_CNT  = 3'(RD_WS);

  state_t            state, state_nxt;
  logic              owner;
  logic              last_grant;
  logic              wr;
  logic [2:0]        cnt;
  logic              avr_pend;
  logic              pick_dma;
  logic              load;
  logic              capture;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_a;
  logic [7:0]        sel_wdata;

  assign avr_pend  = bus.avr_cs & (bus.avr_oe | bus.avr_we);
  // DMA wins when alone, or on a tie when AVR held the previous grant
  assign pick_dma  = bus.dma_req & (~avr_pend | (last_grant == OWN_AVR));
  assign sel_we    = pick_dma ? bus.dma_we    : bus.avr_we;
  assign sel_a     = pick_dma ? bus.dma_a     : bus.avr_a;
  assign sel_wdata = pick_dma ? bus.dma_wdata : bus.avr_dout;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (avr_pend | bus.dma_req) begin
          state_nxt = ACCESS;
          load      = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == 3'd0) begin
          state_nxt = DONE;
          capture   = ~wr;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner         <= OWN_AVR;
      last_grant    <= OWN_DMA;
      wr            <= 1'b0;
      cnt           <= 3'd0;
      bus.mem_a     <= '0;
      bus.mem_wdata <= 8'h00;
      bus.avr_din   <= 8'h00;
      bus.dma_rdata <= 8'h00;
    end else begin
      if (load) begin
        owner         <= pick_dma;
        last_grant    <= pick_dma;
        wr            <= sel_we;
        bus.mem_a     <= sel_a;
        bus.mem_wdata <= sel_wdata;
        cnt           <= sel_we ? 3'd0 : RD_CNT;
      end else if ((state == ACCESS) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        if (owner == OWN_DMA) bus.dma_rdata <= bus.mem_rdata;
        else                  bus.avr_din   <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en   = (state == ACCESS);
  assign bus.mem_we   = (state == ACCESS) & wr;
  assign bus.avr_wait = avr_pend & ~((state == DONE) & (owner == OWN_AVR));
  assign bus.dma_ack  = (state == DONE) & (owner == OWN_DMA);

endmodule
